// File: rtl/aquila_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aquila_bus_pkg
// Purpose  : Shared FSM encodings, error data and region match helper for
//            the Aquila data-bus router.
// Revision : 1.0  initial release
// ============================================================================
package aquila_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_e;

    // Widest address the region helper accepts; narrower buses zero-extend.
    localparam int   c_MAX_XLEN  = 64;
    // Replicated across the data width to form the error reply payload.
    localparam logic c_ERR_DATA  = 1'b0;

    function automatic logic region_hit(
        input logic [c_MAX_XLEN-1:0] addr,
        input logic [c_MAX_XLEN-1:0] base,
        input logic [c_MAX_XLEN-1:0] mask
    );
        return (addr & mask) == (base & mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aquila_region_decoder.sv
`default_nettype none
// ============================================================================
// Module   : aquila_region_decoder
// Purpose  : Combinational base/mask region match; lowest matching port wins.
// Revision : 1.0  initial release
// ============================================================================
module aquila_region_decoder
    import aquila_bus_pkg::*;
#(
    parameter int                     XLEN        = 64,
    parameter int                     N_PORTS     = 4,
    parameter logic [N_PORTS*XLEN-1:0] REGION_BASE = {N_PORTS{{XLEN{1'b0}}}},
    parameter logic [N_PORTS*XLEN-1:0] REGION_MASK = {N_PORTS{{XLEN{1'b0}}}},
    parameter int                     PORT_W      = $clog2(N_PORTS)
) (
    input  logic [XLEN-1:0]   p_addr_i,
    output logic              hit_o,
    output logic [PORT_W-1:0] port_o
);

    // Scan from the top down so the lowest matching index is the last write.
    always_comb begin
        hit_o  = 1'b0;
        port_o = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            if (region_hit(c_MAX_XLEN'(p_addr_i),
                           c_MAX_XLEN'(REGION_BASE[k*XLEN +: XLEN]),
                           c_MAX_XLEN'(REGION_MASK[k*XLEN +: XLEN]))) begin
                hit_o  = 1'b1;
                port_o = PORT_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/aquila_dbus_router.sv
`default_nettype none
// ============================================================================
// Module   : aquila_dbus_router
// Purpose  : Routes single-outstanding core data requests to N_PORTS targets,
//            returning the target reply or an error on unmapped/timeout.
// Revision : 1.0  initial release
// ============================================================================
module aquila_dbus_router
    import aquila_bus_pkg::*;
#(
    parameter int                     XLEN           = 64,
    parameter int                     N_PORTS        = 4,
    parameter logic [N_PORTS*XLEN-1:0] REGION_BASE    = {N_PORTS{{XLEN{1'b0}}}},
    parameter logic [N_PORTS*XLEN-1:0] REGION_MASK    = {N_PORTS{{XLEN{1'b0}}}},
    parameter int                     TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       p_strobe_i,
    input  logic [XLEN-1:0]            p_addr_i,
    input  logic                       p_rw_i,
    input  logic [XLEN/8-1:0]          p_byte_enable_i,
    input  logic [XLEN-1:0]            p_data_i,
    input  logic                       p_force_i,
    input  logic [$clog2(N_PORTS)-1:0] p_force_port_i,
    output logic                       p_ready_o,
    output logic [XLEN-1:0]            p_data_o,
    output logic                       p_err_o,
    output logic                       busy_o,
    output logic [N_PORTS-1:0]         s_strobe_o,
    output logic [N_PORTS-1:0]         s_rw_o,
    output logic [XLEN-1:0]            s_addr_o,
    output logic [XLEN/8-1:0]          s_byte_enable_o,
    output logic [XLEN-1:0]            s_data_o,
    input  logic [N_PORTS-1:0]         s_ready_i,
    input  logic [N_PORTS*XLEN-1:0]    s_data_i
);

    localparam int PORT_W = $clog2(N_PORTS);
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [PORT_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;

    logic                w_dec_hit;
    logic [PORT_W-1:0]   w_dec_port;
    logic                w_hit;
    logic [PORT_W-1:0]   w_port;
    logic                w_tmo;
    logic                w_ready;
    logic                w_err;
    logic [XLEN-1:0]     w_rdata;
    logic [N_PORTS-1:0]  w_strobe;
    logic [XLEN-1:0]     w_s_data [N_PORTS];

    aquila_region_decoder #(
        .XLEN        (XLEN),
        .N_PORTS     (N_PORTS),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK),
        .PORT_W      (PORT_W)
    ) u_decoder (
        .p_addr_i (p_addr_i),
        .hit_o    (w_dec_hit),
        .port_o   (w_dec_port)
    );

    for (genvar g = 0; g < N_PORTS; g++) begin : g_split_rdata
        assign w_s_data[g] = s_data_i[g*XLEN +: XLEN];
    end

    // A forced index outside the port range is treated as unmapped.
    assign w_hit  = p_force_i ? (int'(p_force_port_i) < N_PORTS) : w_dec_hit;
    assign w_port = p_force_i ? p_force_port_i : w_dec_port;
    assign w_tmo  = (tmo_cnt_q == c_TMO_LAST);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        tmo_cnt_d = tmo_cnt_q;
        w_ready   = 1'b0;
        w_err     = 1'b0;
        w_rdata   = '0;
        w_strobe  = '0;
        case (state_q)
            S_IDLE: begin
                if (p_strobe_i) begin
                    tmo_cnt_d = '0;
                    if (w_hit) begin
                        w_strobe[w_port] = 1'b1;
                        sel_d            = w_port;
                        state_d          = S_WAIT;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_WAIT: begin
                if (!w_tmo) begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
                // Ready takes priority over an expiring timeout.
                if (s_ready_i[sel_q]) begin
                    w_ready = 1'b1;
                    w_rdata = w_s_data[sel_q];
                    state_d = S_IDLE;
                end else if (w_tmo) begin
                    w_ready = 1'b1;
                    w_err   = 1'b1;
                    w_rdata = {XLEN{c_ERR_DATA}};
                    state_d = S_IDLE;
                end else begin
                    w_rdata = w_s_data[sel_q];
                end
            end
            S_ERR: begin
                w_ready = 1'b1;
                w_err   = 1'b1;
                w_rdata = {XLEN{c_ERR_DATA}};
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // Reset silences every output, including a reply pending from an abandoned transaction.
    assign p_ready_o       = w_ready & ~rst_i;
    assign p_err_o         = w_err & ~rst_i;
    assign p_data_o        = rst_i ? '0 : w_rdata;
    assign busy_o          = (state_q != S_IDLE) & ~rst_i;
    assign s_strobe_o      = rst_i ? '0 : w_strobe;
    assign s_rw_o          = rst_i ? '0 : (w_strobe & {N_PORTS{p_rw_i}});
    assign s_addr_o        = rst_i ? '0 : p_addr_i;
    assign s_byte_enable_o = rst_i ? '0 : p_byte_enable_i;
    assign s_data_o        = rst_i ? '0 : p_data_i;

endmodule
`default_nettype wire

// File: tb/tb_aquila_dbus_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_aquila_dbus_router
// Purpose  : Directed self-checking bench for aquila_dbus_router.
// Revision : 1.0  initial release
// ============================================================================
module tb_aquila_dbus_router;

    localparam int XLEN = 64;
    localparam int N    = 4;
    localparam int TMO  = 16;

    logic              clk;
    logic              rst;
    logic              p_strobe;
    logic [XLEN-1:0]   p_addr;
    logic              p_rw;
    logic [XLEN/8-1:0] p_be;
    logic [XLEN-1:0]   p_wdata;
    logic              p_force;
    logic [1:0]        p_force_port;
    logic              p_ready;
    logic [XLEN-1:0]   p_rdata;
    logic              p_err;
    logic              busy;
    logic [N-1:0]      s_strobe;
    logic [N-1:0]      s_rw;
    logic [XLEN-1:0]   s_addr;
    logic [XLEN/8-1:0] s_be;
    logic [XLEN-1:0]   s_wdata;
    logic [N-1:0]      s_ready;
    logic [N*XLEN-1:0] s_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    aquila_dbus_router #(
        .XLEN           (XLEN),
        .N_PORTS        (N),
        .REGION_BASE    ({64'hF000_0000, 64'hC000_0000, 64'h8000_0000, 64'h0000_0000}),
        .REGION_MASK    ({64'hF000_0000, 64'hF000_0000, 64'hC000_0000, 64'hF000_0000}),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .p_strobe_i      (p_strobe),
        .p_addr_i        (p_addr),
        .p_rw_i          (p_rw),
        .p_byte_enable_i (p_be),
        .p_data_i        (p_wdata),
        .p_force_i       (p_force),
        .p_force_port_i  (p_force_port),
        .p_ready_o       (p_ready),
        .p_data_o        (p_rdata),
        .p_err_o         (p_err),
        .busy_o          (busy),
        .s_strobe_o      (s_strobe),
        .s_rw_o          (s_rw),
        .s_addr_o        (s_addr),
        .s_byte_enable_o (s_be),
        .s_data_o        (s_wdata),
        .s_ready_i       (s_ready),
        .s_data_i        (s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic settle();
        #1;
    endtask

    task automatic request(input logic [63:0] addr, input logic rw, input logic [63:0] wd);
        p_strobe = 1'b1;
        p_addr   = addr;
        p_rw     = rw;
        p_wdata  = wd;
    endtask

    initial begin
        rst = 1'b1; p_strobe = 1'b0; p_addr = '0; p_rw = 1'b0; p_be = 8'hFF;
        p_wdata = '0; p_force = 1'b0; p_force_port = '0; s_ready = '0; s_rdata = '0;

        // Reset: strobe held high must not leak out.
        @(negedge clk); @(negedge clk);
        request(64'hC000_0010, 1'b1, 64'h77);
        s_ready = 4'b0100;
        settle();
        check_val("rst_strobe", 64'(s_strobe), 64'h0);
        check_val("rst_rw",     64'(s_rw),     64'h0);
        check_val("rst_ready",  64'(p_ready),  64'h0);
        check_val("rst_busy",   64'(busy),     64'h0);
        check_val("rst_addr",   s_addr,        64'h0);
        check_val("rst_data",   p_rdata,       64'h0);
        @(negedge clk);
        rst = 1'b0; p_strobe = 1'b0; s_ready = '0;
        settle();
        check_val("idle_ready", 64'(p_ready), 64'h0);

        // Mapped read to port 2, reply 3 cycles after accept.
        @(negedge clk);
        request(64'hC000_0010, 1'b0, 64'h0);
        p_be = 8'h0F;
        settle();
        check_val("rd_strobe", 64'(s_strobe), 64'h4);
        check_val("rd_rw",     64'(s_rw),     64'h0);
        check_val("rd_addr",   s_addr,        64'hC000_0010);
        check_val("rd_be",     64'(s_be),     64'h0F);
        check_val("rd_busy0",  64'(busy),     64'h0);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            p_strobe = 1'b0;
            settle();
            check_val("rd_busy_w",  64'(busy),     64'h1);
            check_val("rd_noready", 64'(p_ready),  64'h0);
            check_val("rd_nostb",   64'(s_strobe), 64'h0);
        end
        @(negedge clk);
        s_ready = 4'b0100;
        s_rdata[2*XLEN +: XLEN] = 64'hDEAD;
        settle();
        check_val("rd_ready", 64'(p_ready), 64'h1);
        check_val("rd_data",  p_rdata,      64'hDEAD);
        check_val("rd_err",   64'(p_err),   64'h0);
        check_val("rd_busy3", 64'(busy),    64'h1);
        @(negedge clk);
        s_ready = '0;
        settle();
        check_val("rd_done_busy",  64'(busy),    64'h0);
        check_val("rd_done_ready", 64'(p_ready), 64'h0);
        check_val("rd_done_data",  p_rdata,      64'h0);

        // Unmapped write.
        @(negedge clk);
        request(64'h4000_0000, 1'b1, 64'h1234);
        settle();
        check_val("um_strobe", 64'(s_strobe), 64'h0);
        check_val("um_rw",     64'(s_rw),     64'h0);
        check_val("um_wdata",  s_wdata,       64'h1234);
        @(negedge clk);
        p_strobe = 1'b0;
        settle();
        check_val("um_ready", 64'(p_ready), 64'h1);
        check_val("um_err",   64'(p_err),   64'h1);
        check_val("um_data",  p_rdata,      64'h0);
        check_val("um_busy",  64'(busy),    64'h1);
        @(negedge clk);
        settle();
        check_val("um_after", 64'(p_ready), 64'h0);

        // Timeout on port 1, then late ready ignored, then port 0 normal.
        @(negedge clk);
        request(64'h8000_0000, 1'b0, 64'h0);
        s_rdata[1*XLEN +: XLEN] = 64'hBEEF;
        settle();
        check_val("to_strobe", 64'(s_strobe), 64'h2);
        for (int c = 1; c < TMO; c++) begin
            @(negedge clk);
            p_strobe = 1'b0;
            settle();
            check_val("to_wait_ready", 64'(p_ready), 64'h0);
        end
        @(negedge clk);
        settle();
        check_val("to_ready", 64'(p_ready), 64'h1);
        check_val("to_err",   64'(p_err),   64'h1);
        check_val("to_data",  p_rdata,      64'h0);
        @(negedge clk);
        s_ready = 4'b0010;
        settle();
        check_val("late_ready", 64'(p_ready), 64'h0);
        check_val("late_busy",  64'(busy),    64'h0);
        @(negedge clk);
        s_ready = '0;
        request(64'h0000_1000, 1'b1, 64'hAA);
        settle();
        check_val("p0_strobe", 64'(s_strobe), 64'h1);
        check_val("p0_rw",     64'(s_rw),     64'h1);
        @(negedge clk);
        p_strobe = 1'b0;
        s_ready = 4'b0001;
        s_rdata[0 +: XLEN] = 64'h55;
        settle();
        check_val("p0_ready", 64'(p_ready), 64'h1);
        check_val("p0_data",  p_rdata,      64'h55);
        check_val("p0_err",   64'(p_err),   64'h0);

        // Forced routing: address decodes to port 0 but port 1 is forced.
        @(negedge clk);
        s_ready = '0;
        request(64'h0000_0100, 1'b0, 64'h0);
        p_force = 1'b1; p_force_port = 2'd1;
        settle();
        check_val("frc_strobe", 64'(s_strobe), 64'h2);
        @(negedge clk);
        p_strobe = 1'b0; p_force = 1'b0;
        s_ready = 4'b0001;
        s_rdata[0 +: XLEN] = 64'h1111;
        s_rdata[1*XLEN +: XLEN] = 64'h2222;
        settle();
        check_val("frc_other_ready", 64'(p_ready), 64'h0);
        @(negedge clk);
        s_ready = 4'b0010;
        settle();
        check_val("frc_ready", 64'(p_ready), 64'h1);
        check_val("frc_data",  p_rdata,      64'h2222);

        // Ready arriving exactly at timeout expiry wins.
        @(negedge clk);
        s_ready = '0;
        request(64'hC000_0000, 1'b0, 64'h0);
        s_rdata[2*XLEN +: XLEN] = 64'hCAFE;
        settle();
        check_val("exp_strobe", 64'(s_strobe), 64'h4);
        for (int c = 1; c < TMO; c++) begin
            @(negedge clk);
            p_strobe = 1'b0;
        end
        @(negedge clk);
        s_ready = 4'b0100;
        settle();
        check_val("exp_ready", 64'(p_ready), 64'h1);
        check_val("exp_err",   64'(p_err),   64'h0);
        check_val("exp_data",  p_rdata,      64'hCAFE);

        // Strobe while busy is dropped; reset mid-transaction gives no reply.
        @(negedge clk);
        s_ready = '0;
        request(64'hF000_0000, 1'b0, 64'h0);
        settle();
        check_val("bz_strobe", 64'(s_strobe), 64'h8);
        @(negedge clk);
        request(64'hC000_0000, 1'b0, 64'h0);
        settle();
        check_val("bz_second_strobe", 64'(s_strobe), 64'h0);
        check_val("bz_busy",          64'(busy),     64'h1);
        @(negedge clk);
        p_strobe = 1'b0;
        rst = 1'b1;
        s_ready = 4'b1000;
        s_rdata[3*XLEN +: XLEN] = 64'h9999;
        settle();
        check_val("bz_rst_ready", 64'(p_ready), 64'h0);
        check_val("bz_rst_data",  p_rdata,      64'h0);
        check_val("bz_rst_busy",  64'(busy),    64'h0);
        @(negedge clk);
        rst = 1'b0;
        settle();
        check_val("bz_post_ready", 64'(p_ready), 64'h0);
        check_val("bz_post_busy",  64'(busy),    64'h0);
        check_val("bz_post_err",   64'(p_err),   64'h0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
